// File: rtl/rr_arb16_pkg.sv
// Shared constants and types for the 16-way round-robin arbiter.
// Back-to-back regrant is enabled by defining ARB_BACK_TO_BACK_EN.
package rr_arb16_pkg;

  localparam int NREQ  = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [7:0] hold_t;

endpackage

// File: rtl/rr_arb16_ctrl_onehot_enc.sv
// One-hot to 4-bit index encoder.
// Any input that is not exactly one-hot encodes to 0.
module onehot_enc_16to4
  import rr_arb16_pkg::*;
(
  input  logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

  logic              is_onehot;
  logic [NREQ-1:0]   low_clr;
  logic [IDX_W-1:0]  acc;

  assign low_clr   = onehot & (onehot - NREQ'(1));
  assign is_onehot = (onehot != '0) && (low_clr == '0);

  always_comb begin
    acc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (onehot[i]) acc = acc | IDX_W'(i);
    end
  end

  assign idx = is_onehot ? acc : '0;

endmodule

// File: rtl/rr_arb16_ctrl.sv
// Round-robin arbiter: 16 requesters, held grant, done/timeout release.
// Define ARB_BACK_TO_BACK_EN to regrant on the release cycle (no bubble).
module rr_arb16_ctrl
  import rr_arb16_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        done,
  output logic        grant_val,
  output logic [15:0] grant,
  output logic [3:0]  grant_idx,
  output logic        timeout,
  output logic        err_sticky
);

  localparam hold_t HOLD_MAX = hold_t'(MAX_HOLD);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  hold_t            hold_q, hold_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             gval_q, gval_d;
  logic             tout_q, tout_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] scan_ptr;
  logic [NREQ-1:0]  rot;
  logic [NREQ-1:0]  rot_low;
  logic [NREQ-1:0]  win;
  logic [IDX_W-1:0] win_idx;
  logic [2*NREQ-1:0] rot_w;
  logic [2*NREQ-1:0] back_w;
  logic             release_now;

  // While granting, scan from the slot after the holder.
  assign scan_ptr = (state_q == GRANT) ? idx_q + IDX_W'(1) : ptr_q;

  assign rot_w   = {req, req} >> scan_ptr;
  assign rot     = rot_w[NREQ-1:0];
  assign rot_low = rot & (~rot + NREQ'(1));
  assign back_w  = {rot_low, rot_low} << scan_ptr;
  assign win     = back_w[2*NREQ-1:NREQ];

  onehot_enc_16to4 u_enc (
    .onehot (win),
    .idx    (win_idx)
  );

  assign release_now = done || (hold_q == HOLD_MAX);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    gval_d  = gval_q;
    tout_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = GRANT;
          grant_d = win;
          idx_d   = win_idx;
          gval_d  = 1'b1;
          hold_d  = hold_t'(1);
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d   = idx_q + IDX_W'(1);
          tout_d  = !done;
          err_d   = err_q | !done;
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          gval_d  = 1'b0;
          hold_d  = '0;
`ifdef ARB_BACK_TO_BACK_EN
          if (req != '0) begin
            state_d = GRANT;
            grant_d = win;
            idx_d   = win_idx;
            gval_d  = 1'b1;
            hold_d  = hold_t'(1);
          end
`endif
        end else begin
          hold_d = hold_q + hold_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      gval_q  <= 1'b0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      gval_q  <= gval_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
    end
  end

  assign grant_val  = gval_q;
  assign grant      = grant_q;
  assign grant_idx  = idx_q;
  assign timeout    = tout_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_rr_arb16_ctrl.sv
// Directed bench for rr_arb16_ctrl: default instance plus MAX_HOLD=3 instance.
// Expected values are hand-derived for each step.
module tb_rr_arb16_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic [15:0] req, req2;
  logic        done, done2;
  logic        gval, gval2;
  logic [15:0] grant, grant2;
  logic [3:0]  gidx, gidx2;
  logic        tout, tout2;
  logic        err, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arb16_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant_val  (gval),
    .grant      (grant),
    .grant_idx  (gidx),
    .timeout    (tout),
    .err_sticky (err)
  );

  rr_arb16_ctrl #(.MAX_HOLD(3)) dut_t (
    .clk        (clk),
    .reset      (reset2),
    .req        (req2),
    .done       (done2),
    .grant_val  (gval2),
    .grant      (grant2),
    .grant_idx  (gidx2),
    .timeout    (tout2),
    .err_sticky (err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req = 16'hFFFF; done = 1'b0;
    reset2 = 1'b1; req2 = 16'h0000; done2 = 1'b0;
    step();
    step();
    check("rst_gval", 32'(gval), 32'd0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idx", 32'(gidx), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tout", 32'(tout), 32'd0);
    reset = 1'b0;
    step();
    check("first_grant", 32'(grant), 32'h0001);
    check("first_idx", 32'(gidx), 32'd0);

`ifndef ARB_BACK_TO_BACK_EN
    req = 16'h8001;
    done = 1'b1; step();
    check("rot_bubble1", 32'(gval), 32'd0);
    check("rot_bubble1_grant", 32'(grant), 32'h0);
    done = 1'b0; step();
    check("rot_idx15a", 32'(gidx), 32'd15);
    check("rot_grant15a", 32'(grant), 32'h8000);
    done = 1'b1; step();
    check("rot_bubble2", 32'(gval), 32'd0);
    done = 1'b0; step();
    check("rot_idx0", 32'(gidx), 32'd0);
    check("rot_gval0", 32'(gval), 32'd1);
    done = 1'b1; step();
    check("rot_bubble3", 32'(gval), 32'd0);
    done = 1'b0; step();
    check("rot_idx15b", 32'(gidx), 32'd15);

    req = 16'h0004;
    done = 1'b1; step();
    check("wrap_bubble", 32'(gval), 32'd0);
    done = 1'b0; step();
    check("wrap_idx", 32'(gidx), 32'd2);
    check("wrap_grant", 32'(grant), 32'h0004);
    done = 1'b1; step();

    req = 16'h0020; done = 1'b0; step();
    check("hold_idx", 32'(gidx), 32'd5);
    req = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_grant%0d", i), 32'(grant), 32'h0020);
    end
    done = 1'b1; step();
    check("hold_release", 32'(gval), 32'd0);
    step();
    check("idle_done_ignored", 32'(gval), 32'd0);
    check("no_err_default", 32'(err), 32'd0);
    done = 1'b0;

    reset2 = 1'b0; req2 = 16'h0010;
    step();
    check("to_c1_gval", 32'(gval2), 32'd1);
    check("to_c1_idx", 32'(gidx2), 32'd4);
    step();
    check("to_c2_gval", 32'(gval2), 32'd1);
    step();
    check("to_c3_gval", 32'(gval2), 32'd1);
    check("to_c3_tout", 32'(tout2), 32'd0);
    step();
    check("to_rel_gval", 32'(gval2), 32'd0);
    check("to_pulse", 32'(tout2), 32'd1);
    check("to_err", 32'(err2), 32'd1);
    step();
    check("to_regrant_idx", 32'(gidx2), 32'd4);
    check("to_regrant_gval", 32'(gval2), 32'd1);
    check("to_pulse_once", 32'(tout2), 32'd0);
    step();
    step();
    done2 = 1'b1; step();
    check("tie_gval", 32'(gval2), 32'd0);
    check("tie_no_pulse", 32'(tout2), 32'd0);
    check("tie_err_kept", 32'(err2), 32'd1);
    done2 = 1'b0; step();
    check("mid_grant_up", 32'(gval2), 32'd1);
    reset2 = 1'b1; step();
    check("mid_rst_gval", 32'(gval2), 32'd0);
    check("mid_rst_tout", 32'(tout2), 32'd0);
    check("mid_rst_err", 32'(err2), 32'd0);
`else
    req = 16'h0003; done = 1'b1;
    step();
    check("b2b_idx1", 32'(gidx), 32'd1);
    check("b2b_gval1", 32'(gval), 32'd1);
    step();
    check("b2b_idx0", 32'(gidx), 32'd0);
    check("b2b_gval0", 32'(gval), 32'd1);
    step();
    check("b2b_idx1b", 32'(gidx), 32'd1);
    check("b2b_grant", 32'(grant), 32'h0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
